wmem_arbiter: RTL and testbench
===============================

WMEM_ARBITER -- requirements
Module: wmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter LINE_W, default 512, read line width.
REQ-003 SHALL have parameter LINE_BYTES, default 64, address stride per line.
REQ-004 SHALL have parameter CNT_W, default 8, burst length field width.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports rdn_req / dnn_req  input  1  requester wants a weight burst.
REQ-008 SHALL have ports rdn_base / dnn_base  input  ADDR_W  burst start address, sampled at grant.
REQ-009 SHALL have ports rdn_lines / dnn_lines  input  CNT_W  burst length in lines, sampled at grant.
REQ-010 SHALL have ports rdn_gnt / dnn_gnt  output  1  one-cycle grant pulse.
REQ-011 SHALL have ports rdn_data_vld / dnn_data_vld  output  1  routed line valid.
REQ-012 SHALL have port line_data  output  LINE_W  registered read line, shared by both requesters.
REQ-013 SHALL have ports rdn_done / dnn_done  output  1  one-cycle burst-complete pulse.
REQ-014 SHALL have port buffer_addr_valid  input  1  memory ready; no grant while low.
REQ-015 SHALL have port read_request_valid  output  1  one-cycle read request pulse.
REQ-016 SHALL have port address  output  ADDR_W  read address, valid with read_request_valid.
REQ-017 SHALL have ports data_valid  input  1  and read_data  input  LINE_W  memory read return.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
REQ-019 IDLE: when buffer_addr_valid=1 and any req=1, SHALL pulse winner's gnt, latch base/lines/owner, go ISSUE next cycle.
REQ-020 Both reqs in same cycle: winner per REQ-033; loser keeps waiting; no request is lost while held.
REQ-021 ISSUE: SHALL pulse read_request_valid with address = base + idx*LINE_BYTES (mod 2^ADDR_W, wraps silently), go WAIT.
REQ-022 WAIT: on data_valid SHALL register read_data to line_data and pulse owner's data_vld next cycle; idx+1; if idx+1 == lines go DONE else ISSUE.
REQ-023 Exactly one read outstanding; next request no earlier than cycle after data_valid.
REQ-024 DONE: SHALL pulse owner's done for one cycle, return to IDLE; new grant earliest following cycle.
REQ-025 lines == 0: SHALL grant, skip memory, pulse done one cycle after grant.
REQ-026 Requester deasserting req mid-burst SHALL NOT abort the burst.
REQ-027 data_valid in IDLE/ISSUE/DONE SHALL be ignored; no data_vld generated.
REQ-028 Non-owner data_vld and done SHALL stay 0 throughout a burst.

Reset
REQ-029 rst_n low SHALL force IDLE immediately, including mid-burst; burst is abandoned, no done issued.
REQ-030 Reset values: all gnt/data_vld/done/read_request_valid = 0, address = 0, line_data = 0, idx = 0, last-owner = DNN (so RDN wins first tie).
REQ-031 After reset release a pending read return SHALL be ignored per REQ-027.

Configuration
REQ-032 Macro WMEM_ARB_RR_EN selects arbitration policy.
REQ-033 Defined: round-robin, tie goes to requester not granted last. Undefined: fixed priority, RDN always wins ties; last-owner register omitted.

Structure
REQ-034 Shared package afu_pkg SHALL hold ADDR_W/LINE_W defaults, typedef t_wmem_owner enum {OWN_RDN, OWN_DNN}, typedef t_wmem_state enum {IDLE, ISSUE, WAIT, DONE}.
REQ-035 Arbitration decision SHALL live in sub-module wmem_arb_pick (two reqs, last-owner in; winner, valid out).

Verification
REQ-036 RDN only, base=0x1000, lines=3, 2-cycle memory latency -> addresses 0x1000,0x1040,0x1080; three rdn_data_vld; one rdn_done; dnn outputs 0.
REQ-037 Both req same cycle after reset, lines=1 each -> RDN granted first, then DNN; with WMEM_ARB_RR_EN two more ties alternate DNN,RDN; without it RDN wins both.
REQ-038 dnn_lines=0 -> dnn_gnt then dnn_done next cycle; read_request_valid never asserted.
REQ-039 rst_n low during WAIT of 4-line burst -> all outputs 0 same cycle; late data_valid after release produces no data_vld.
REQ-040 buffer_addr_valid=0 with rdn_req=1 for 10 cycles -> no grant; grant one cycle after it rises.
REQ-041 base=0xFFFFFFC0, lines=2 -> second address 0x00000000.

Source files
------------

// File: rtl/afu_pkg.sv
// Shared AFU types: weight-memory arbiter owner/state encodings and default bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package afu_pkg;

  localparam int WMEM_ADDR_W = 32;
  localparam int WMEM_LINE_W = 512;

  typedef enum logic {
    OWN_RDN = 1'b0,
    OWN_DNN = 1'b1
  } t_wmem_owner;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } t_wmem_state;

endpackage

// File: rtl/wmem_arb_pick.sv
// Chooses which weight requester is served next from the two request lines and the last owner.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is actually taken.
module wmem_arb_pick
  import afu_pkg::*;
(
  input  logic        rdn_req,
  input  logic        dnn_req,
  input  t_wmem_owner last_owner,
  output t_wmem_owner winner,
  output logic        valid
);

  // A lone request wins outright; on a tie the requester not served last wins.
  always_comb begin
    valid  = rdn_req | dnn_req;
    winner = OWN_RDN;
    if (rdn_req && dnn_req) begin
      winner = (last_owner == OWN_RDN) ? OWN_DNN : OWN_RDN;
    end else if (dnn_req) begin
      winner = OWN_DNN;
    end
  end

endmodule

// File: rtl/wmem_arbiter.sv
// Shares one weight memory read port between RDN and DNN, streaming one line per read; WMEM_ARB_RR_EN selects round-robin ties (else RDN priority).
// Latency: grant 1 cycle after req seen in IDLE; read request 1 cycle after grant or after previous line; done 1 cycle after last line.
// Backpressure: no grant while buffer_addr_valid is low; a single read outstanding, next issued only after data_valid returns.
module wmem_arbiter
  import afu_pkg::*;
#(
  parameter int ADDR_W     = WMEM_ADDR_W,
  parameter int LINE_W     = WMEM_LINE_W,
  parameter int LINE_BYTES = 64,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdn_req,
  input  logic              dnn_req,
  input  logic [ADDR_W-1:0] rdn_base,
  input  logic [ADDR_W-1:0] dnn_base,
  input  logic [CNT_W-1:0]  rdn_lines,
  input  logic [CNT_W-1:0]  dnn_lines,
  output logic              rdn_gnt,
  output logic              dnn_gnt,
  output logic              rdn_data_vld,
  output logic              dnn_data_vld,
  output logic [LINE_W-1:0] line_data,
  output logic              rdn_done,
  output logic              dnn_done,
  input  logic              buffer_addr_valid,
  output logic              read_request_valid,
  output logic [ADDR_W-1:0] address,
  input  logic              data_valid,
  input  logic [LINE_W-1:0] read_data
);

  t_wmem_state       state;
  t_wmem_state       state_nxt;
  t_wmem_owner       owner;
  t_wmem_owner       pick_owner;
  t_wmem_owner       last_owner;
  logic              pick_vld;
  logic              grant_go;
  logic [ADDR_W-1:0] sel_base;
  logic [CNT_W-1:0]  sel_lines;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  lines_q;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W:0]    idx_inc;
  logic              last_line;
  logic [ADDR_W-1:0] line_off;
  logic              rdn_gnt_d;
  logic              dnn_gnt_d;
  logic              rdn_dvld_d;
  logic              dnn_dvld_d;
  logic              rdn_done_d;
  logic              dnn_done_d;
  logic              rd_req_d;

  wmem_arb_pick u_pick (
    .rdn_req    (rdn_req),
    .dnn_req    (dnn_req),
    .last_owner (last_owner),
    .winner     (pick_owner),
    .valid      (pick_vld)
  );

  // Only an idle arbiter with a ready memory accepts a new burst.
  assign grant_go  = (state == IDLE) && buffer_addr_valid && pick_vld;
  assign sel_base  = (pick_owner == OWN_RDN) ? rdn_base  : dnn_base;
  assign sel_lines = (pick_owner == OWN_RDN) ? rdn_lines : dnn_lines;
  // One extra bit so a full-length burst (lines = 2^CNT_W-1) still compares exactly.
  assign idx_inc   = {1'b0, idx} + {{CNT_W{1'b0}}, 1'b1};
  assign last_line = (idx_inc == {1'b0, lines_q});
  // Address arithmetic is modulo 2^ADDR_W; a burst crossing the top simply wraps.
  assign line_off  = ADDR_W'(idx) * ADDR_W'(LINE_BYTES);

`ifdef WMEM_ARB_RR_EN
  // Remember who was served last so that ties alternate between requesters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_DNN;
    end else if (grant_go) begin
      last_owner <= pick_owner;
    end
  end
`else
  // Fixed priority: pretending DNN was always last makes RDN win every tie.
  assign last_owner = OWN_DNN;
`endif

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: zero-length bursts skip memory and go straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant_go) state_nxt = (sel_lines == '0) ? DONE : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (data_valid) state_nxt = last_line ? DONE : ISSUE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: pulses routed only to the current (or newly picked) owner.
  always_comb begin
    rdn_gnt_d  = grant_go && (pick_owner == OWN_RDN);
    dnn_gnt_d  = grant_go && (pick_owner == OWN_DNN);
    rd_req_d   = (state == ISSUE);
    rdn_dvld_d = (state == WAIT) && data_valid && (owner == OWN_RDN);
    dnn_dvld_d = (state == WAIT) && data_valid && (owner == OWN_DNN);
    rdn_done_d = (state == DONE) && (owner == OWN_RDN);
    dnn_done_d = (state == DONE) && (owner == OWN_DNN);
  end

  // Register all pulses so every output is glitch-free and cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdn_gnt            <= 1'b0;
      dnn_gnt            <= 1'b0;
      read_request_valid <= 1'b0;
      rdn_data_vld       <= 1'b0;
      dnn_data_vld       <= 1'b0;
      rdn_done           <= 1'b0;
      dnn_done           <= 1'b0;
    end else begin
      rdn_gnt            <= rdn_gnt_d;
      dnn_gnt            <= dnn_gnt_d;
      read_request_valid <= rd_req_d;
      rdn_data_vld       <= rdn_dvld_d;
      dnn_data_vld       <= dnn_dvld_d;
      rdn_done           <= rdn_done_d;
      dnn_done           <= dnn_done_d;
    end
  end

  // Burst context captured at grant, then address and returned line per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_RDN;
      base_q    <= '0;
      lines_q   <= '0;
      idx       <= '0;
      address   <= '0;
      line_data <= '0;
    end else begin
      if (grant_go) begin
        owner   <= pick_owner;
        base_q  <= sel_base;
        lines_q <= sel_lines;
        idx     <= '0;
      end
      if (state == ISSUE) begin
        address <= base_q + line_off;
      end
      if ((state == WAIT) && data_valid) begin
        line_data <= read_data;
        idx       <= idx_inc[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_wmem_arbiter.sv
// Bench for wmem_arbiter: random and directed bursts scored against a transaction-level expected-event queue.
// Latency: checks grant/request/data/done spacing where it is fixed by the design.
// Backpressure: memory responder with random return latency; buffer_addr_valid held low at round starts.
`timescale 1ns/1ps
module tb_wmem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int LINE_W     = 512;
  localparam int LINE_BYTES = 64;
  localparam int CNT_W      = 8;

  logic              clk;
  logic              rst_n;
  logic              rdn_req, dnn_req;
  logic [ADDR_W-1:0] rdn_base, dnn_base;
  logic [CNT_W-1:0]  rdn_lines, dnn_lines;
  logic              rdn_gnt, dnn_gnt;
  logic              rdn_data_vld, dnn_data_vld;
  logic [LINE_W-1:0] line_data;
  logic              rdn_done, dnn_done;
  logic              buffer_addr_valid;
  logic              read_request_valid;
  logic [ADDR_W-1:0] address;
  logic              data_valid;
  logic [LINE_W-1:0] read_data;

  wmem_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .LINE_BYTES(LINE_BYTES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rdn_req(rdn_req), .dnn_req(dnn_req),
    .rdn_base(rdn_base), .dnn_base(dnn_base),
    .rdn_lines(rdn_lines), .dnn_lines(dnn_lines),
    .rdn_gnt(rdn_gnt), .dnn_gnt(dnn_gnt),
    .rdn_data_vld(rdn_data_vld), .dnn_data_vld(dnn_data_vld),
    .line_data(line_data),
    .rdn_done(rdn_done), .dnn_done(dnn_done),
    .buffer_addr_valid(buffer_addr_valid),
    .read_request_valid(read_request_valid),
    .address(address),
    .data_valid(data_valid), .read_data(read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_GNT, EV_REQ, EV_DVLD, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t          kind;
    bit                own_d;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    int                gap;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  last_ev_cyc   = 0;
  int  round_gnt_cyc = -1;
  int  dvld_cnt      = 0;
  bit  m_last_d      = 1'b1;
  bit  mem_auto      = 1'b1;
  bit  noise_en      = 1'b0;
  int  mem_lat       = -1;
  bit  mem_pend      = 1'b0;
  int  mem_wait      = 0;
  logic [ADDR_W-1:0] mem_addr = '0;

  // Memory line content is a fixed function of its address.
  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = a ^ (32'h9E3779B9 * 32'(i + 1));
    return r;
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input bit own_d, input logic [ADDR_W-1:0] a, input int gap);
    ev_t e;
    e.kind = k; e.own_d = own_d; e.addr = a; e.data = line_of(a); e.gap = gap;
    sb.push_back(e);
  endtask

  // Expected event sequence of one whole burst.
  task automatic expect_burst(input bit own_d, input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] lines, input int first_gap);
    logic [ADDR_W-1:0] a;
    push_ev(EV_GNT, own_d, '0, first_gap);
    for (int i = 0; i < int'(lines); i++) begin
      a = base + 32'(i) * 32'(LINE_BYTES);
      push_ev(EV_REQ, own_d, a, 1);
      push_ev(EV_DVLD, own_d, a, -1);
    end
    push_ev(EV_DONE, own_d, '0, 1);
  endtask

  // Arbitration rule: lone request wins; tie by policy (1 = DNN).
  function automatic bit model_pick(input bit wr, input bit wd);
    if (wr && wd) begin
`ifdef WMEM_ARB_RR_EN
      return (m_last_d == 1'b0);
`else
      return 1'b0;
`endif
    end
    return !wr;
  endfunction

  // Monitor: pop and compare one expected event per observed pulse.
  task automatic observe(input ev_kind_t k, input bit own_d);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected_event: kind %0d owner_dnn %0d at cycle %0d, expected none", k, own_d, cyc);
    end else begin
      e = sb.pop_front();
      chk_int("event_kind", int'(k), int'(e.kind));
      if (k != EV_REQ) chk_int("event_owner", int'(own_d), int'(e.own_d));
      if (k == EV_REQ) chk_vec("req_address", LINE_W'(address), LINE_W'(e.addr));
      if (k == EV_DVLD) chk_vec("line_data", line_data, e.data);
      if (e.gap >= 0) chk_int("event_spacing", cyc - last_ev_cyc, e.gap);
    end
    if (k == EV_GNT && round_gnt_cyc < 0) round_gnt_cyc = cyc;
    if (k == EV_DVLD) dvld_cnt++;
    last_ev_cyc = cyc;
  endtask

  initial forever begin
    @(negedge clk);
    if (rdn_gnt)            observe(EV_GNT, 1'b0);
    if (dnn_gnt)            observe(EV_GNT, 1'b1);
    if (read_request_valid) observe(EV_REQ, 1'b0);
    if (rdn_data_vld)       observe(EV_DVLD, 1'b0);
    if (dnn_data_vld)       observe(EV_DVLD, 1'b1);
    if (rdn_done)           observe(EV_DONE, 1'b0);
    if (dnn_done)           observe(EV_DONE, 1'b1);
  end

  // Requesters drop req once granted and scramble their burst fields.
  initial forever begin
    @(negedge clk);
    if (rdn_gnt) begin rdn_req = 1'b0; rdn_base = $urandom; rdn_lines = CNT_W'($urandom); end
    if (dnn_gnt) begin dnn_req = 1'b0; dnn_base = $urandom; dnn_lines = CNT_W'($urandom); end
  end

  // Memory responder: one return per request after a random latency, plus idle noise.
  initial forever begin
    @(negedge clk);
    if (mem_auto) begin
      data_valid = 1'b0;
      if (mem_pend) begin
        if (mem_wait == 0) begin
          data_valid = 1'b1; read_data = line_of(mem_addr); mem_pend = 1'b0;
        end else begin
          mem_wait--;
        end
      end else if (noise_en && $urandom_range(0, 2) == 0) begin
        data_valid = 1'b1;
        for (int i = 0; i < 16; i++) read_data[i*32 +: 32] = $urandom;
      end
      if (read_request_valid) begin
        mem_pend = 1'b1; mem_addr = address;
        mem_wait = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 3));
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || rdn_req || dnn_req) && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d events still expected after %0d cycles", sb.size(), budget);
      sb.delete(); rdn_req = 1'b0; dnn_req = 1'b0;
    end
  endtask

  task automatic run_round(input bit wr, input bit wd, input logic [ADDR_W-1:0] br, input logic [ADDR_W-1:0] bd,
                           input logic [CNT_W-1:0] lr, input logic [CNT_W-1:0] ld, input int bav_low);
    bit first_d;
    int raise_cyc;
    @(negedge clk);
    round_gnt_cyc = -1;
    first_d = model_pick(wr, wd);
    if (first_d) expect_burst(1'b1, bd, ld, -1);
    else         expect_burst(1'b0, br, lr, -1);
    m_last_d = first_d;
    if (wr && wd) begin
      if (first_d) expect_burst(1'b0, br, lr, 1);
      else         expect_burst(1'b1, bd, ld, 1);
      m_last_d = !first_d;
    end
    buffer_addr_valid = (bav_low == 0);
    if (wr) begin rdn_req = 1'b1; rdn_base = br; rdn_lines = lr; end
    if (wd) begin dnn_req = 1'b1; dnn_base = bd; dnn_lines = ld; end
    raise_cyc = cyc;
    if (bav_low > 0) begin
      repeat (bav_low) @(negedge clk);
      buffer_addr_valid = 1'b1;
      raise_cyc = cyc;
    end
    wait_drain(2000);
    if (bav_low > 0) chk_int("gnt_after_ready_rise", round_gnt_cyc, raise_cyc + 1);
    noise_en = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    noise_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk_int({tag, "_rdn_gnt"}, int'(rdn_gnt), 0);
    chk_int({tag, "_dnn_gnt"}, int'(dnn_gnt), 0);
    chk_int({tag, "_rdn_data_vld"}, int'(rdn_data_vld), 0);
    chk_int({tag, "_dnn_data_vld"}, int'(dnn_data_vld), 0);
    chk_int({tag, "_rdn_done"}, int'(rdn_done), 0);
    chk_int({tag, "_dnn_done"}, int'(dnn_done), 0);
    chk_int({tag, "_read_request_valid"}, int'(read_request_valid), 0);
    chk_vec({tag, "_address"}, LINE_W'(address), '0);
    chk_vec({tag, "_line_data"}, line_data, '0);
  endtask

  // Reset asserted while a 4-line burst waits on memory; late return must be dropped.
  task automatic reset_mid_burst();
    int n;
    int dv0;
    mem_auto = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    push_ev(EV_GNT, 1'b0, '0, -1);
    push_ev(EV_REQ, 1'b0, 32'h0000_9000, 1);
    rdn_base = 32'h0000_9000; rdn_lines = 8'd4; rdn_req = 1'b1; buffer_addr_valid = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk_int("reset_burst_started", sb.size(), 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_burst_reset");
    sb.delete();
    m_last_d = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    dv0 = dvld_cnt;
    @(negedge clk);
    data_valid = 1'b1; read_data = line_of(32'h0000_9000);
    @(negedge clk);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk_int("late_return_ignored", dvld_cnt - dv0, 0);
    mem_auto = 1'b1;
  endtask

  initial begin
    logic [1:0] who;
    rst_n = 1'b0;
    rdn_req = 1'b0; dnn_req = 1'b0;
    rdn_base = '0; dnn_base = '0; rdn_lines = '0; dnn_lines = '0;
    buffer_addr_valid = 1'b1; data_valid = 1'b0; read_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    // Ties from reset: RDN first; later ties follow the arbitration policy.
    run_round(1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, 8'd1, 8'd1, 0);
    run_round(1'b1, 1'b0, 32'h0000_4000, 32'h0,        8'd1, 8'd0, 0);
    run_round(1'b1, 1'b1, 32'h0000_5000, 32'h0000_6000, 8'd1, 8'd1, 0);
    run_round(1'b1, 1'b1, 32'h0000_5800, 32'h0000_6800, 8'd1, 8'd1, 0);
    // Three-line RDN burst with fixed two-cycle memory latency.
    mem_lat = 2;
    run_round(1'b1, 1'b0, 32'h0000_1000, 32'h0, 8'd3, 8'd0, 0);
    mem_lat = -1;
    // Zero-length DNN burst.
    run_round(1'b0, 1'b1, 32'h0, 32'h0000_7000, 8'd0, 8'd0, 0);
    // Memory not ready for ten cycles.
    run_round(1'b1, 1'b0, 32'h0000_8000, 32'h0, 8'd2, 8'd0, 10);
    // Address wrap at the top of the space.
    run_round(1'b1, 1'b0, 32'hFFFF_FFC0, 32'h0, 8'd2, 8'd0, 0);
    for (int r = 0; r < 40; r++) begin
      who = 2'($urandom_range(1, 3));
      run_round(who[0], who[1], $urandom, $urandom,
                CNT_W'($urandom_range(0, 5)), CNT_W'($urandom_range(0, 5)),
                int'($urandom_range(0, 3)));
    end
    reset_mid_burst();
    run_round(1'b1, 1'b1, 32'h0000_A000, 32'h0000_B000, 8'd2, 8'd1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
